// File: rtl/cnn_sdiv_22s_8s_seq_if.sv
// Purpose : operand/result and ap_* handshake bundle for the sequential signed divider.
// Latency : n/a (wires only).
// Backpress: n/a; the divider accepts ap_start only while ap_idle is high.
//
// Ports (as interface members):
//   ap_start  master->slave  request, sampled by the divider only in IDLE
//   din0      master->slave  signed dividend
//   din1      master->slave  signed divisor
//   ap_ready  slave->master  operands captured this cycle
//   ap_idle   slave->master  divider is in IDLE
//   ap_done   slave->master  one-cycle pulse, dout/rem/ovf freshly updated
//   dout      slave->master  signed quotient (truncated toward zero, saturated)
//   rem       slave->master  signed remainder, sign follows the dividend
//   ovf       slave->master  quotient saturated or divide-by-zero
interface cnn_sdiv_22s_8s_seq_if #(
    parameter int din0_WIDTH = 22,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 14
);
    logic                         ap_start;
    logic                         ap_ready;
    logic                         ap_idle;
    logic                         ap_done;
    logic signed [din0_WIDTH-1:0] din0;
    logic signed [din1_WIDTH-1:0] din1;
    logic signed [dout_WIDTH-1:0] dout;
    logic signed [din1_WIDTH-1:0] rem;
    logic                         ovf;

    modport master (
        output ap_start, din0, din1,
        input  ap_ready, ap_idle, ap_done, dout, rem, ovf
    );

    modport slave (
        input  ap_start, din0, din1,
        output ap_ready, ap_idle, ap_done, dout, rem, ovf
    );
endinterface

// File: rtl/cnn_sdiv_22s_8s_seq.sv
// Purpose : restoring radix-2 signed divider, 22s / 8s -> 14s quotient (saturating) + 8s remainder.
// Latency : start accepted at edge T -> ap_done high in cycle T+24; one op every 25 cycles max.
// Backpress: none on the result side; ap_start is only honoured in IDLE (ap_ready echoes acceptance).
//
// Ports:
//   ap_clk    clock, all state on the rising edge
//   ap_rst_n  synchronous active-low reset; discards any in-flight operation
//   bus       cnn_sdiv_22s_8s_seq_if.slave: ap_start/din0/din1 in, ap_ready/ap_idle/ap_done/dout/rem/ovf out
module cnn_sdiv_22s_8s_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 22,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 14
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    cnn_sdiv_22s_8s_seq_if.slave  bus
);

    // ID only tags the instance; it has no functional effect.
    if (ID < 0) begin : g_id_tag
    end

    localparam int CW = $clog2(din0_WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(din0_WIDTH - 1);

    // Saturation limits, both as quotient magnitudes (dividend width) and as output codes.
    localparam logic [din0_WIDTH-1:0] QPOS_MAG = din0_WIDTH'((1 << (dout_WIDTH - 1)) - 1);
    localparam logic [din0_WIDTH-1:0] QNEG_MAG = din0_WIDTH'(1 << (dout_WIDTH - 1));
    localparam logic [dout_WIDTH-1:0] QPOS     = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] QNEG     = {1'b1, {(dout_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    // Working registers.
    // quo_q starts as |din0| and is shifted left once per CALC cycle; the freed LSBs collect
    // the quotient bits, so after the last step it holds the 22-bit magnitude quotient.
    logic [din0_WIDTH-1:0] quo_q;
    logic [din1_WIDTH-1:0] dmag_q;
    logic [din1_WIDTH-1:0] prem_q;
    logic [CW-1:0]         cnt_q;
    logic                  neg0_q;
    logic                  negq_q;
    logic                  dz_q;

    // Result registers, held from one FIX to the next.
    logic [dout_WIDTH-1:0] dout_q;
    logic [din1_WIDTH-1:0] rem_q;
    logic                  ovf_q;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.ap_start) state_nx = S_CALC;
            S_CALC:  if (cnt_q == '0)  state_nx = S_FIX;
            S_FIX:   state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign bus.ap_idle  = (state == S_IDLE);
    assign bus.ap_ready = (state == S_IDLE) && bus.ap_start;
    assign bus.ap_done  = (state == S_DONE);

    // ------------------------------------------------------------------
    // Operand magnitudes at capture. Two's complement negate in the same
    // width is exact for the most negative value when read as unsigned
    // (-2^21 -> 2^21, -128 -> 128), so no extra bit is needed.
    // ------------------------------------------------------------------
    logic [din0_WIDTH-1:0] din0_u;
    logic [din0_WIDTH-1:0] din0_mag;
    logic [din1_WIDTH-1:0] din1_u;
    logic [din1_WIDTH-1:0] din1_mag;

    assign din0_u   = bus.din0;
    assign din1_u   = bus.din1;
    assign din0_mag = din0_u[din0_WIDTH-1] ? -din0_u : din0_u;
    assign din1_mag = din1_u[din1_WIDTH-1] ? -din1_u : din1_u;

    // ------------------------------------------------------------------
    // One restoring step. The partial remainder is always below |d| <= 128,
    // so after the shift it fits one bit wider than the divisor.
    // ------------------------------------------------------------------
    logic [din1_WIDTH:0] r_shift;
    logic [din1_WIDTH:0] r_sub;
    logic                q_bit;

    assign r_shift = {prem_q, quo_q[din0_WIDTH-1]};
    assign r_sub   = r_shift - {1'b0, dmag_q};
    assign q_bit   = (r_shift >= {1'b0, dmag_q});

    // ------------------------------------------------------------------
    // Sign fix-up and saturation, evaluated during FIX.
    // Saturation is decided on the magnitude: a negative result may reach
    // one count further (-8192) than a positive one (8191).
    // ------------------------------------------------------------------
    logic [dout_WIDTH-1:0] fix_dout;
    logic [din1_WIDTH-1:0] fix_rem;
    logic                  fix_ovf;

    always_comb begin
        fix_dout = quo_q[dout_WIDTH-1:0];
        fix_rem  = prem_q;
        fix_ovf  = 1'b0;
        if (dz_q) begin
            fix_dout = neg0_q ? QNEG : QPOS;
            fix_rem  = '0;
            fix_ovf  = 1'b1;
        end else begin
            if (negq_q) begin
                if (quo_q > QNEG_MAG) begin
                    fix_dout = QNEG;
                    fix_ovf  = 1'b1;
                end else begin
                    fix_dout = -quo_q[dout_WIDTH-1:0];
                end
            end else if (quo_q > QPOS_MAG) begin
                fix_dout = QPOS;
                fix_ovf  = 1'b1;
            end
            if (neg0_q) begin
                fix_rem = -prem_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            quo_q  <= '0;
            dmag_q <= '0;
            prem_q <= '0;
            cnt_q  <= '0;
            neg0_q <= 1'b0;
            negq_q <= 1'b0;
            dz_q   <= 1'b0;
            dout_q <= '0;
            rem_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.ap_start) begin
                        quo_q  <= din0_mag;
                        dmag_q <= din1_mag;
                        prem_q <= '0;
                        cnt_q  <= CNT_INIT;
                        neg0_q <= din0_u[din0_WIDTH-1];
                        negq_q <= din0_u[din0_WIDTH-1] ^ din1_u[din1_WIDTH-1];
                        dz_q   <= (din1_u == '0);
                    end
                end
                S_CALC: begin
                    // With a zero divisor every step "subtracts" nothing; the
                    // garbage quotient is replaced in FIX, but timing is unchanged.
                    prem_q <= q_bit ? r_sub[din1_WIDTH-1:0] : r_shift[din1_WIDTH-1:0];
                    quo_q  <= {quo_q[din0_WIDTH-2:0], q_bit};
                    cnt_q  <= cnt_q - CW'(1);
                end
                S_FIX: begin
                    dout_q <= fix_dout;
                    rem_q  <= fix_rem;
                    ovf_q  <= fix_ovf;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.dout = dout_q;
    assign bus.rem  = rem_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_cnn_sdiv_22s_8s_seq.sv
// Purpose : self-checking bench for cnn_sdiv_22s_8s_seq against an integer-division model.
// Latency : expects ap_ready in the start cycle and ap_done 24 cycles after the capturing edge.
// Backpress: exercises back-to-back starts with ap_start held high.
module tb_cnn_sdiv_22s_8s_seq;

    logic ap_clk;
    logic ap_rst_n;

    cnn_sdiv_22s_8s_seq_if bus ();

    cnn_sdiv_22s_8s_seq #(
        .ID         (1),
        .din0_WIDTH (22),
        .din1_WIDTH (8),
        .dout_WIDTH (14)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // C-style division with a zero-divisor rule and 14-bit saturation.
    function automatic void model(input int a, input int b,
                                  output longint q, output longint r, output longint o);
        int qi;
        if (b == 0) begin
            q = (a < 0) ? -8192 : 8191;
            r = 0;
            o = 1;
        end else begin
            qi = a / b;
            r  = a % b;
            o  = 0;
            q  = qi;
            if (qi > 8191) begin
                q = 8191;
                o = 1;
            end else if (qi < -8192) begin
                q = -8192;
                o = 1;
            end
        end
    endfunction

    task automatic run_op(input logic signed [21:0] a, input logic signed [7:0] b, input string tag);
        longint eq, er, eo;
        bit     early;
        model(a, b, eq, er, eo);
        @(negedge ap_clk);
        bus.ap_start = 1'b1;
        bus.din0     = a;
        bus.din1     = b;
        #1;
        check({tag, "_ready"}, bus.ap_ready, 1);
        @(posedge ap_clk);
        #1;
        bus.ap_start = 1'b0;
        bus.din0     = 22'($urandom);
        bus.din1     = 8'($urandom);
        check({tag, "_ready_drop"}, bus.ap_ready, 0);
        early = 1'b0;
        for (int k = 1; k < 24; k++) begin
            @(negedge ap_clk);
            if (bus.ap_done) early = 1'b1;
            if (k == 1) check({tag, "_busy"}, bus.ap_idle, 0);
        end
        check({tag, "_early_done"}, early, 0);
        @(negedge ap_clk);
        check({tag, "_done"}, bus.ap_done, 1);
        check({tag, "_dout"}, bus.dout, eq);
        check({tag, "_rem"}, bus.rem, er);
        check({tag, "_ovf"}, bus.ovf, eo);
        @(negedge ap_clk);
        check({tag, "_done_pulse"}, bus.ap_done, 0);
        check({tag, "_idle"}, bus.ap_idle, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog");
    end

    int dir_a [10] = '{1000, -1000, 1000, -2097152, -2097152, -8192, 500, -5, 2097151, -8193};
    int dir_b [10] = '{7,    7,     -128, -1,       1,        1,     0,   0,  -128,    1};

    initial begin
        logic signed [21:0] ra;
        logic signed [7:0]  rb;
        longint eq, er, eo;
        logic signed [21:0] qa [$];
        logic signed [7:0]  qb [$];
        int last_ready, nready;
        bit saw_done;

        bus.ap_start = 1'b0;
        bus.din0     = '0;
        bus.din1     = '0;
        ap_rst_n     = 1'b0;
        repeat (3) @(negedge ap_clk);
        check("rst_idle",  bus.ap_idle,  1);
        check("rst_ready", bus.ap_ready, 0);
        check("rst_done",  bus.ap_done,  0);
        check("rst_dout",  bus.dout, 0);
        check("rst_rem",   bus.rem,  0);
        check("rst_ovf",   bus.ovf,  0);
        ap_rst_n = 1'b1;

        // Directed corner cases.
        for (int i = 0; i < 10; i++) begin
            run_op(22'(dir_a[i]), 8'(dir_b[i]), $sformatf("dir%0d", i));
        end

        // Randomized operands, biased so not every quotient saturates.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = 22'($urandom); rb = 8'($urandom); end
                1: begin ra = 22'(int'($urandom_range(0, 131071)) - 65536); rb = 8'($urandom); end
                2: begin
                    ra = 22'($urandom);
                    case ($urandom_range(0, 4))
                        0: rb = -8'sd128;
                        1: rb = -8'sd1;
                        2: rb = 8'sd1;
                        3: rb = 8'sd127;
                        default: rb = 8'sd0;
                    endcase
                end
                default: begin ra = 22'(int'($urandom_range(0, 2047)) - 1024); rb = 8'($urandom); end
            endcase
            run_op(ra, rb, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of a calculation.
        run_op(22'sd1000, 8'sd7, "pre_rst");
        @(negedge ap_clk);
        bus.ap_start = 1'b1;
        bus.din0     = 22'sd1000;
        bus.din1     = 8'sd7;
        @(posedge ap_clk);
        #1;
        bus.ap_start = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin
            @(negedge ap_clk);
            if (bus.ap_done) saw_done = 1'b1;
        end
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        check("midrst_idle", bus.ap_idle, 1);
        check("midrst_dout", bus.dout, 0);
        check("midrst_rem",  bus.rem,  0);
        check("midrst_ovf",  bus.ovf,  0);
        ap_rst_n = 1'b1;
        repeat (30) begin
            @(negedge ap_clk);
            if (bus.ap_done) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 0);
        run_op(22'sd1000, 8'sd7, "post_rst");

        // ap_start held high with operands changing every cycle.
        last_ready = -1;
        nready     = 0;
        for (int cyc = 0; cyc < 135; cyc++) begin
            @(negedge ap_clk);
            bus.din0     = 22'(int'($urandom_range(0, 262143)) - 131072);
            bus.din1     = 8'($urandom);
            bus.ap_start = (cyc < 101);
            #1;
            if (bus.ap_ready) begin
                qa.push_back(bus.din0);
                qb.push_back(bus.din1);
                if (last_ready >= 0) check("b2b_interval", cyc - last_ready, 25);
                last_ready = cyc;
                nready++;
            end
            if (bus.ap_done) begin
                if (qa.size() == 0) begin
                    check("b2b_spurious_done", 1, 0);
                end else begin
                    ra = qa.pop_front();
                    rb = qb.pop_front();
                    model(ra, rb, eq, er, eo);
                    check("b2b_dout", bus.dout, eq);
                    check("b2b_rem",  bus.rem,  er);
                    check("b2b_ovf",  bus.ovf,  eo);
                end
            end
        end
        bus.ap_start = 1'b0;
        check("b2b_readies", nready, 5);
        check("b2b_pending", qa.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
